logic_unit_pipe: RTL and testbench



---
 rtl/logic_unit_pkg.sv | 15 +
 rtl/logic_op_core.sv | 34 +++
 rtl/logic_unit_pipe.sv | 113 +++++++++++
 tb/tb_logic_unit_pipe.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/logic_unit_pkg.sv
// Shared constants for the pipelined bitwise logic unit.
package logic_unit_pkg;

    localparam int unsigned OP_W = 3;

    localparam logic [OP_W-1:0] OP_AND  = 3'b000;
    localparam logic [OP_W-1:0] OP_OR   = 3'b001;
    localparam logic [OP_W-1:0] OP_XOR  = 3'b010;
    localparam logic [OP_W-1:0] OP_NOR  = 3'b011;
    localparam logic [OP_W-1:0] OP_NAND = 3'b100;
    localparam logic [OP_W-1:0] OP_XNOR = 3'b101;
    localparam logic [OP_W-1:0] OP_NOT  = 3'b110;
    localparam logic [OP_W-1:0] OP_PASS = 3'b111;

endpackage

// File: rtl/logic_op_core.sv
// Combinational bitwise operation plus result flags (zero, all-ones, parity).
module logic_op_core
    import logic_unit_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] x_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [OP_W-1:0]  op_i,
    output logic [WIDTH-1:0] y_o,
    output logic             zero_o,
    output logic             ones_o,
    output logic             parity_o
);

    always_comb begin
        y_o = x_i;
        unique case (op_i)
            OP_AND:  y_o = x_i & b_i;
            OP_OR:   y_o = x_i | b_i;
            OP_XOR:  y_o = x_i ^ b_i;
            OP_NOR:  y_o = ~(x_i | b_i);
            OP_NAND: y_o = ~(x_i & b_i);
            OP_XNOR: y_o = ~(x_i ^ b_i);
            OP_NOT:  y_o = ~x_i;
            OP_PASS: y_o = x_i;
        endcase
    end

    assign zero_o   = ~|y_o;
    assign ones_o   = &y_o;
    assign parity_o = ^y_o;

endmodule

// File: rtl/logic_unit_pipe.sv
// Pipelined logic unit: accumulator-chained operand select, STAGES elastic stages,
// valid/ready handshake on both sides; flags travel alongside each result.
module logic_unit_pipe
    import logic_unit_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [OP_W-1:0]  op_i,
    input  logic             acc_en_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] y_o,
    output logic             zero_o,
    output logic             ones_o,
    output logic             parity_o
);

    // Stage payload: {zero, ones, parity, y}
    localparam int unsigned DW = WIDTH + 3;

    logic [WIDTH-1:0]  acc_q, acc_d;
    logic              init_q;
    logic [STAGES-1:0] vld_q, vld_d, adv;
    logic [STAGES:0]   load;
    logic [DW-1:0]     dat_q [STAGES];
    logic [DW-1:0]     dat_d [STAGES];

    logic [WIDTH-1:0] x, res_y;
    logic             res_zero, res_ones, res_parity;
    logic             accept;

    assign x = acc_en_i ? acc_q : a_i;

    logic_op_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .x_i      (x),
        .b_i      (b_i),
        .op_i     (op_i),
        .y_o      (res_y),
        .zero_o   (res_zero),
        .ones_o   (res_ones),
        .parity_o (res_parity)
    );

    // load[i]: stage i may take new contents; resolved from the output backwards.
    always_comb begin
        load[STAGES] = out_ready_i;
        adv          = '0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            adv[i]  = vld_q[i] && load[i+1];
            load[i] = !vld_q[i] || adv[i];
        end
    end

    // init_q keeps the unit from accepting until the first edge after reset release.
    assign in_ready_o = init_q && load[0];
    assign accept     = in_valid_i && in_ready_o;
    assign acc_d      = accept ? res_y : acc_q;

    always_comb begin
        vld_d = vld_q;
        for (int i = 0; i < STAGES; i++) begin
            dat_d[i] = dat_q[i];
        end
        if (load[0]) begin
            vld_d[0] = accept;
            if (accept) begin
                dat_d[0] = {res_zero, res_ones, res_parity, res_y};
            end
        end
        for (int i = 1; i < STAGES; i++) begin
            if (load[i]) begin
                vld_d[i] = vld_q[i-1];
                if (vld_q[i-1]) begin
                    dat_d[i] = dat_q[i-1];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_q <= 1'b0;
            acc_q  <= '0;
            vld_q  <= '0;
            for (int i = 0; i < STAGES; i++) begin
                dat_q[i] <= '0;
            end
        end else begin
            init_q <= 1'b1;
            acc_q  <= acc_d;
            vld_q  <= vld_d;
            for (int i = 0; i < STAGES; i++) begin
                dat_q[i] <= dat_d[i];
            end
        end
    end

    assign out_valid_o = vld_q[STAGES-1];
    assign y_o         = dat_q[STAGES-1][WIDTH-1:0];
    assign parity_o    = dat_q[STAGES-1][WIDTH];
    assign ones_o      = dat_q[STAGES-1][WIDTH+1];
    assign zero_o      = dat_q[STAGES-1][WIDTH+2];

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed, table-driven bench for logic_unit_pipe (WIDTH=32, STAGES=2).
module tb_logic_unit_pipe;

    typedef struct {
        logic [2:0]  op;
        logic        acc_en;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] y;
        logic        z;
        logic        o;
        logic        p;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  op = 3'b000;
    logic        acc_en = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] y;
    logic        zero, ones, parity;

    int n_pass = 0;
    int n_total = 0;

    vec_t tbl[$];
    vec_t burst[$];

    always #5 clk = ~clk;

    logic_unit_pipe #(
        .WIDTH  (32),
        .STAGES (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .op_i        (op),
        .acc_en_i    (acc_en),
        .a_i         (a),
        .b_i         (b),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .y_o         (y),
        .zero_o      (zero),
        .ones_o      (ones),
        .parity_o    (parity)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %08h expected %08h (t=%0t)", nm, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v);
        in_valid = 1'b1;
        op       = v.op;
        acc_en   = v.acc_en;
        a        = v.a;
        b        = v.b;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        acc_en   = 1'b0;
    endtask

    task automatic chk_out(input string nm, input vec_t v);
        chk({nm, ".valid"}, {31'd0, out_valid}, 32'd1);
        chk({nm, ".y"}, y, v.y);
        chk({nm, ".flags"}, {29'd0, zero, ones, parity}, {29'd0, v.z, v.o, v.p});
    endtask

    // Consecutive requests, one per cycle; results must follow one per cycle in order.
    task automatic run_burst(input string nm);
        for (int k = 0; k < burst.size(); k++) begin
            drive(burst[k]);
            chk({nm, ".in_ready"}, {31'd0, in_ready}, 32'd1);
            tick();
            if (k > 0) chk_out($sformatf("%s[%0d]", nm, k - 1), burst[k-1]);
        end
        idle();
        tick();
        chk_out($sformatf("%s[%0d]", nm, burst.size() - 1), burst[burst.size()-1]);
        tick();
        chk({nm, ".drain"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        // Table: single requests, latency and one-cycle pulse checked per entry
        tbl.push_back('{3'b000, 1'b0, 32'hFF00FF00, 32'h0F0F0F0F, 32'h0F000F00, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{3'b001, 1'b0, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{3'b010, 1'b0, 32'h00000007, 32'h00000000, 32'h00000007, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{3'b011, 1'b0, 32'hFF00FF00, 32'h0F0F0F0F, 32'h00F000F0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{3'b100, 1'b0, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{3'b101, 1'b0, 32'h12345678, 32'h12345678, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{3'b110, 1'b0, 32'hFF00FF00, 32'h12345678, 32'h00FF00FF, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{3'b111, 1'b0, 32'h00000001, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{3'b000, 1'b0, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 1'b1, 1'b0, 1'b0});

        // Reset held with a request offered: nothing may be accepted
        rst_n    = 1'b0;
        in_valid = 1'b1;
        op       = 3'b001;
        a        = 32'h12345678;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst.out_valid", {31'd0, out_valid}, 32'd0);
            chk("rst.y", y, 32'h0);
            chk("rst.in_ready", {31'd0, in_ready}, 32'd0);
        end
        rst_n = 1'b1;
        idle();
        #1;
        chk("rel.in_ready_pre", {31'd0, in_ready}, 32'd0);
        tick();
        chk("rel.in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        chk("rel.no_accept", {31'd0, out_valid}, 32'd0);

        // Accumulator chain from reset value 0; operand a must be ignored
        burst = {};
        burst.push_back('{3'b001, 1'b1, 32'hDEADBEEF, 32'h0000000F, 32'h0000000F, 1'b0, 1'b0, 1'b0});
        burst.push_back('{3'b001, 1'b1, 32'hDEADBEEF, 32'h000000F0, 32'h000000FF, 1'b0, 1'b0, 1'b0});
        burst.push_back('{3'b010, 1'b1, 32'hDEADBEEF, 32'h000000FF, 32'h00000000, 1'b1, 1'b0, 1'b0});
        burst.push_back('{3'b110, 1'b1, 32'hDEADBEEF, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0});
        run_burst("acc");

        foreach (tbl[i]) begin
            drive(tbl[i]);
            chk($sformatf("tbl[%0d].in_ready", i), {31'd0, in_ready}, 32'd1);
            tick();
            idle();
            chk($sformatf("tbl[%0d].lat1", i), {31'd0, out_valid}, 32'd0);
            tick();
            chk_out($sformatf("tbl[%0d]", i), tbl[i]);
            tick();
            chk($sformatf("tbl[%0d].pulse", i), {31'd0, out_valid}, 32'd0);
        end

        burst = {};
        burst.push_back('{3'b000, 1'b0, 32'hFF00FF00, 32'h0F0F0F0F, 32'h0F000F00, 1'b0, 1'b0, 1'b0});
        burst.push_back('{3'b010, 1'b0, 32'hFF00FF00, 32'h0F0F0F0F, 32'hF00FF00F, 1'b0, 1'b0, 1'b0});
        burst.push_back('{3'b011, 1'b0, 32'hFF00FF00, 32'h0F0F0F0F, 32'h00F000F0, 1'b0, 1'b0, 1'b0});
        burst.push_back('{3'b101, 1'b0, 32'hFF00FF00, 32'h0F0F0F0F, 32'h0FF00FF0, 1'b0, 1'b0, 1'b0});
        run_burst("b2b");

        // Backpressure: two requests fill the pipe, the third stalls
        out_ready = 1'b0;
        drive('{3'b001, 1'b0, 32'h00000001, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0});
        chk("bp.rdy0", {31'd0, in_ready}, 32'd1);
        tick();
        drive('{3'b001, 1'b0, 32'h00000002, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0});
        chk("bp.rdy1", {31'd0, in_ready}, 32'd1);
        tick();
        drive('{3'b001, 1'b0, 32'h00000004, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0});
        for (int i = 0; i < 3; i++) begin
            chk("bp.stall_rdy", {31'd0, in_ready}, 32'd0);
            chk("bp.hold_valid", {31'd0, out_valid}, 32'd1);
            chk("bp.hold_y", y, 32'h00000001);
            if (i < 2) tick();
        end
        out_ready = 1'b1;
        #1;
        chk("bp.release_rdy", {31'd0, in_ready}, 32'd1);
        tick();
        idle();
        chk_out("bp.out1", '{3'b001, 1'b0, 32'h0, 32'h0, 32'h00000002, 1'b0, 1'b0, 1'b1});
        tick();
        chk_out("bp.out2", '{3'b001, 1'b0, 32'h0, 32'h0, 32'h00000004, 1'b0, 1'b0, 1'b1});
        tick();
        chk("bp.drain", {31'd0, out_valid}, 32'd0);

        // Asynchronous reset while a result is presented
        drive('{3'b111, 1'b0, 32'hCAFEF00D, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0});
        tick();
        idle();
        tick();
        chk("ar.pre_valid", {31'd0, out_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar.valid_drop", {31'd0, out_valid}, 32'd0);
        chk("ar.y_clear", y, 32'h0);
        tick();
        #3;
        rst_n = 1'b1;
        tick();
        burst = {};
        burst.push_back('{3'b001, 1'b1, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b1});
        run_burst("ar.acc");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
